// File: rtl/me_pkg.sv
// me_pkg: shared definitions for the motion-estimation block loader.
// Holds the loader state encoding, the reference/search memory geometry
// and the packed result record captured from the estimator.
package me_pkg;

    localparam int R_PIXELS = 256;
    localparam int S_PIXELS = 1024;
    localparam int R_AW     = 8;
    localparam int S_AW     = 10;

    // Last raster index of each memory, used to detect the final write.
    localparam logic [R_AW-1:0] R_LAST = R_AW'(R_PIXELS - 1);
    localparam logic [S_AW-1:0] S_LAST = S_AW'(S_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_R,
        LOAD_S,
        LAUNCH,
        RUN,
        RESULT
    } state_t;

    typedef struct packed {
        logic [3:0] motion_x;
        logic [3:0] motion_y;
        logic [7:0] best_dist;
        logic       timeout;
    } result_t;

endpackage

// File: rtl/me_wr_port.sv
// me_wr_port: one registered memory write stage.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   en                - write request for this cycle
//   addr_in, data_in  - address and data of the request
//   we, addr, wdata   - registered write port toward the memory
module me_wr_port #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata
);

    // The enable follows the request every cycle; address and data are only
    // loaded on a real request so the bus stays quiet between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            we <= en;
            if (en) begin
                addr  <= addr_in;
                wdata <= data_in;
            end
        end
    end

endmodule

// File: rtl/me_block_loader.sv
// me_block_loader: writes a 16x16 reference block and a 32x32 search window
// from a raster pixel stream into the R and S memories, then runs the motion
// estimator once and offers its result on a valid/ready port.
// Ports:
//   clock, reset                 - clock and asynchronous active-high reset
//   in_valid/in_ready/in_data    - pixel stream; in_sof marks R pixel 0
//   r_we/r_addr/r_wdata          - R memory write port (256 bytes)
//   s_we/s_addr/s_wdata          - S memory write port (1024 bytes)
//   me_start, me_completed       - estimator level start / done
//   me_motion_x/y, me_best_dist  - estimator result inputs
//   res_valid/res_ready, res_*   - captured result handshake
//   busy                         - high whenever not IDLE
//   sof_abort                    - pulse when a load restarts on in_sof
module me_block_loader
    import me_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int RUN_TIMEOUT = 8191
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              r_we,
    output logic [R_AW-1:0]   r_addr,
    output logic [DATA_W-1:0] r_wdata,
    output logic              s_we,
    output logic [S_AW-1:0]   s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              me_start,
    input  logic              me_completed,
    input  logic [3:0]        me_motion_x,
    input  logic [3:0]        me_motion_y,
    input  logic [7:0]        me_best_dist,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_motion_x,
    output logic [3:0]        res_motion_y,
    output logic [7:0]        res_best_dist,
    output logic              res_timeout,
    output logic              busy,
    output logic              sof_abort
);

    localparam logic [12:0] TIMEOUT_LAST = 13'(RUN_TIMEOUT - 1);
    localparam result_t     RES_RESET    = '{motion_x: 4'h0, motion_y: 4'h0,
                                             best_dist: 8'hFF, timeout: 1'b0};
    localparam result_t     RES_TIMEOUT  = '{motion_x: 4'h0, motion_y: 4'h0,
                                             best_dist: 8'hFF, timeout: 1'b1};

    state_t          state;
    logic [R_AW-1:0] r_cnt;
    logic [S_AW-1:0] s_cnt;
    logic [12:0]     run_cnt;
    result_t         res_q;

    logic            hs;
    logic            r_en;
    logic            s_en;
    logic [R_AW-1:0] r_waddr;

    // The stream is only accepted while loading; these decode straight from
    // the state register, so a reset in RUN clears them immediately.
    assign in_ready  = (state == IDLE) || (state == LOAD_R) || (state == LOAD_S);
    assign busy      = (state != IDLE);
    assign res_valid = (state == RESULT);
    assign hs        = in_valid & in_ready;

    assign res_motion_x  = res_q.motion_x;
    assign res_motion_y  = res_q.motion_y;
    assign res_best_dist = res_q.best_dist;
    assign res_timeout   = res_q.timeout;

    // Write request decode. A start-of-frame pixel always restarts at R[0],
    // whatever phase the load is in; plain pixels in IDLE are dropped.
    always_comb begin
        r_en    = 1'b0;
        s_en    = 1'b0;
        r_waddr = r_cnt;
        if (hs) begin
            if (in_sof) begin
                r_en    = 1'b1;
                r_waddr = '0;
            end else if (state == LOAD_R) begin
                r_en = 1'b1;
            end else if (state == LOAD_S) begin
                s_en = 1'b1;
            end
        end
    end

    me_wr_port #(.AW(R_AW), .DW(DATA_W)) u_r_port (
        .clock   (clock),
        .reset   (reset),
        .en      (r_en),
        .addr_in (r_waddr),
        .data_in (in_data),
        .we      (r_we),
        .addr    (r_addr),
        .wdata   (r_wdata)
    );

    me_wr_port #(.AW(S_AW), .DW(DATA_W)) u_s_port (
        .clock   (clock),
        .reset   (reset),
        .en      (s_en),
        .addr_in (s_cnt),
        .data_in (in_data),
        .we      (s_we),
        .addr    (s_addr),
        .wdata   (s_wdata)
    );

    // Main sequencer. LAUNCH spends one cycle so the last S write reaches
    // memory before me_start rises. me_start drops on the way into RESULT and
    // stays low through the next full load, which is far longer than the
    // estimator needs to clear its counter. The timeout counter stops at its
    // limit; a completion seen in the same cycle as expiry takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            r_cnt     <= '0;
            s_cnt     <= '0;
            run_cnt   <= '0;
            me_start  <= 1'b0;
            sof_abort <= 1'b0;
            res_q     <= RES_RESET;
        end else begin
            sof_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs && in_sof) begin
                        r_cnt <= R_AW'(1);
                        state <= LOAD_R;
                    end
                end
                LOAD_R, LOAD_S: begin
                    if (hs) begin
                        if (in_sof) begin
                            r_cnt     <= R_AW'(1);
                            sof_abort <= 1'b1;
                            state     <= LOAD_R;
                        end else if (state == LOAD_R) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == R_LAST) begin
                                s_cnt <= '0;
                                state <= LOAD_S;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                            if (s_cnt == S_LAST) begin
                                state <= LAUNCH;
                            end
                        end
                    end
                end
                LAUNCH: begin
                    me_start <= 1'b1;
                    run_cnt  <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (me_completed) begin
                        res_q    <= '{motion_x: me_motion_x, motion_y: me_motion_y,
                                      best_dist: me_best_dist, timeout: 1'b0};
                        me_start <= 1'b0;
                        state    <= RESULT;
                    end else if (run_cnt >= TIMEOUT_LAST) begin
                        res_q    <= RES_TIMEOUT;
                        me_start <= 1'b0;
                        state    <= RESULT;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_block_loader.sv
// tb_me_block_loader: directed bench for me_block_loader with a small
// estimator model, a write-address model of the load, and a vector table
// for the short IDLE/restart sequences.
module tb_me_block_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_sof;
    logic [7:0] in_data;
    logic       r_we, s_we;
    logic [7:0] r_addr, r_wdata, s_wdata;
    logic [9:0] s_addr;
    logic       me_start, me_completed;
    logic [3:0] me_motion_x, me_motion_y;
    logic [7:0] me_best_dist;
    logic       res_valid, res_ready, res_timeout, busy, sof_abort;
    logic [3:0] res_motion_x, res_motion_y;
    logic [7:0] res_best_dist;

    me_block_loader #(.DATA_W(8), .RUN_TIMEOUT(8191)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sof        (in_sof),
        .r_we          (r_we),
        .r_addr        (r_addr),
        .r_wdata       (r_wdata),
        .s_we          (s_we),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .me_start      (me_start),
        .me_completed  (me_completed),
        .me_motion_x   (me_motion_x),
        .me_motion_y   (me_motion_y),
        .me_best_dist  (me_best_dist),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_motion_x  (res_motion_x),
        .res_motion_y  (res_motion_y),
        .res_best_dist (res_best_dist),
        .res_timeout   (res_timeout),
        .busy          (busy),
        .sof_abort     (sof_abort)
    );

    always #5 clock = ~clock;

    // Estimator model: counts cycles with start high, cleared while start is
    // low, and reports done 4111 cycles after start when enabled.
    logic estEnable;
    int   estCnt;

    always @(posedge clock or posedge reset) begin
        if (reset) estCnt <= 0;
        else if (!me_start) estCnt <= 0;
        else estCnt <= estCnt + 1;
    end

    assign me_completed = estEnable && me_start && (estCnt >= 4111);
    assign me_motion_x  = 4'd3;
    assign me_motion_y  = 4'd12;
    assign me_best_dist = 8'h1A;

    int checks = 0;
    int errors = 0;

    // Load model state: 0 idle, 1 loading R, 2 loading S, 3 load finished.
    int mPhase, mCnt;
    int badWrites, rWrites, sWrites, abortCount;

    typedef struct {
        logic       vld;
        logic       sof;
        logic [7:0] data;
        logic       expWe;
        logic [7:0] expAddr;
        logic [7:0] expWdata;
        logic       expBusy;
        logic       expAbort;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stream inputs; returns at the following negedge.
    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic clearModel();
        mPhase = 0; mCnt = 0;
        badWrites = 0; rWrites = 0; sWrites = 0; abortCount = 0;
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 1'b0, 8'h00);
        abortCount += int'(sof_abort);
        if (r_we || s_we) badWrites++;
    endtask

    task automatic pushPixel(input logic s, input logic [7:0] d);
        logic expR, expS;
        int   expAddr;
        expR = 1'b0; expS = 1'b0; expAddr = 0;
        if (s) begin mPhase = 1; mCnt = 0; end
        if (mPhase == 1) begin
            expR = 1'b1; expAddr = mCnt; mCnt++;
            if (mCnt == 256) begin mPhase = 2; mCnt = 0; end
        end else if (mPhase == 2) begin
            expS = 1'b1; expAddr = mCnt; mCnt++;
            if (mCnt == 1024) begin mPhase = 3; mCnt = 0; end
        end
        if (in_ready !== 1'b1) badWrites++;
        applyStimulus(1'b1, s, d);
        abortCount += int'(sof_abort);
        rWrites += int'(r_we);
        sWrites += int'(s_we);
        if (r_we !== expR || s_we !== expS) badWrites++;
        else if (expR && (r_addr !== expAddr[7:0] || r_wdata !== d)) badWrites++;
        else if (expS && (s_addr !== expAddr[9:0] || s_wdata !== d)) badWrites++;
    endtask

    // Full load of R then S with pixel i = i & 8'hFF; optional 50% valid
    // duty and optional restart after abortAt R pixels.
    task automatic loadSet(input bit toggle, input int abortAt);
        clearModel();
        for (int i = 0; i < abortAt; i++) pushPixel(i == 0, 8'(i));
        for (int i = 0; i < 1280; i++) begin
            if (toggle) idleStep();
            pushPixel(i == 0, 8'(i));
        end
        checkOutput("load_writes_ok", badWrites, 0);
        checkOutput("load_r_count", rWrites, 256 + abortAt);
        checkOutput("load_s_count", sWrites, 1024);
        checkOutput("load_abort_count", abortCount, (abortAt > 0) ? 1 : 0);
        checkOutput("launch_start_low", me_start, 1'b0);
        checkOutput("launch_ready_low", in_ready, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("start_rise_2cyc", me_start, 1'b1);
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (res_valid !== 1'b1 && cycles < 9000) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            cycles++;
        end
        checkOutput("result_within_bound", res_valid, 1'b1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int unstable;
        in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
        res_ready = 1'b0; estEnable = 1'b1;

        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h11, 1'b1, 8'h01, 8'h11, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h22, 1'b1, 8'h02, 8'h22, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'h33, 1'b1, 8'h00, 8'h33, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 8'h44, 1'b1, 8'h01, 8'h44, 1'b1, 1'b0};

        reset = 1'b1;
        #12;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_best_dist", res_best_dist, 8'hFF);
        checkOutput("reset_res_valid", res_valid, 1'b0);
        checkOutput("reset_me_start", me_start, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_we", {r_we, s_we, sof_abort}, 3'b000);
        checkOutput("reset_addr", {r_addr, s_addr}, 18'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] vector table: IDLE discard, first writes, restart");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].sof, vecs[i].data);
            checkOutput($sformatf("vec%0d_r_we", i), r_we, vecs[i].expWe);
            checkOutput($sformatf("vec%0d_s_we", i), s_we, 1'b0);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d_abort", i), sof_abort, vecs[i].expAbort);
            if (vecs[i].expWe) begin
                checkOutput($sformatf("vec%0d_r_addr", i), r_addr, vecs[i].expAddr);
                checkOutput($sformatf("vec%0d_r_wdata", i), r_wdata, vecs[i].expWdata);
            end
        end
        doReset();

        $display("[TB] nominal load, run and result backpressure");
        loadSet(1'b0, 0);
        waitResult(cycles);
        checkOutput("nominal_latency", cycles, 4112);
        checkOutput("nominal_x", res_motion_x, 4'd3);
        checkOutput("nominal_y", res_motion_y, 4'd12);
        checkOutput("nominal_dist", res_best_dist, 8'h1A);
        checkOutput("nominal_timeout", res_timeout, 1'b0);
        checkOutput("nominal_start_low", me_start, 1'b0);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h5A);
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_motion_x !== 4'd3 ||
                res_motion_y !== 4'd12 || res_best_dist !== 8'h1A || r_we !== 1'b0)
                unstable++;
        end
        checkOutput("backpressure_stable", unstable, 0);
        res_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        res_ready = 1'b0;
        checkOutput("release_busy", busy, 1'b0);
        checkOutput("release_in_ready", in_ready, 1'b1);
        checkOutput("release_res_valid", res_valid, 1'b0);

        $display("[TB] stray pixels then 50 percent valid load");
        clearModel();
        for (int i = 0; i < 5; i++) pushPixel(1'b0, 8'(8'hE0 + i));
        checkOutput("stray_no_writes", rWrites + sWrites, 0);
        checkOutput("stray_idle", busy, 1'b0);
        loadSet(1'b1, 0);
        waitResult(cycles);
        checkOutput("toggle_dist", res_best_dist, 8'h1A);
        res_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        res_ready = 1'b0;

        $display("[TB] restart on sof at R pixel 100");
        loadSet(1'b0, 100);
        waitResult(cycles);
        checkOutput("restart_timeout", res_timeout, 1'b0);
        res_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        res_ready = 1'b0;

        $display("[TB] estimator timeout");
        estEnable = 1'b0;
        loadSet(1'b0, 0);
        waitResult(cycles);
        checkOutput("timeout_cycles", cycles, 8191);
        checkOutput("timeout_flag", res_timeout, 1'b1);
        checkOutput("timeout_dist", res_best_dist, 8'hFF);
        checkOutput("timeout_xy", {res_motion_x, res_motion_y}, 8'h00);
        checkOutput("timeout_start_low", me_start, 1'b0);
        res_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        res_ready = 1'b0;
        estEnable = 1'b1;

        $display("[TB] asynchronous reset in RUN");
        loadSet(1'b0, 0);
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("prereset_start", me_start, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_start", me_start, 1'b0);
        checkOutput("areset_res_valid", res_valid, 1'b0);
        checkOutput("areset_busy", busy, 1'b0);
        checkOutput("areset_in_ready", in_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        clearModel();
        for (int i = 0; i < 10; i++) pushPixel(i == 0, 8'(8'hC0 + i));
        checkOutput("postreset_writes_ok", badWrites, 0);
        checkOutput("postreset_r_count", rWrites, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
